// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM block.
//   MODE_EDGE / MODE_CENTER : counting-mode encoding of the 'center' input
//   duty_slice()            : extracts channel ch's compare value from the
//                             packed per-channel duty bus
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Upper bounds for the generic slice helper; callers size-cast in and out.
    localparam int DUTY_VEC_MAX = 1024;
    localparam int SLICE_MAX    = 32;

    function automatic logic [SLICE_MAX-1:0] duty_slice(
        input logic [DUTY_VEC_MAX-1:0] vec,
        input int                      ch,
        input int                      w
    );
        logic [DUTY_VEC_MAX-1:0] shifted;
        logic [SLICE_MAX-1:0]    mask;
        shifted = vec >> (ch * w);
        mask    = (w >= SLICE_MAX) ? '1 : ((SLICE_MAX'(1) << w) - SLICE_MAX'(1));
        return shifted[SLICE_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk down to a one-cycle tick every i_div+1 cycles.
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : holds the divider at 0 and suppresses the tick
//   i_div     : divisor minus one (0 = tick every cycle)
//   o_tick    : high on the cycle the divider reaches i_div
module pwm_prescaler #(
    parameter int PRE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic [PRE_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [PRE_WIDTH-1:0] r_cnt;
    logic                 w_wrap;

    // '>=' rather than '==' so a divisor lowered below the running count
    // wraps at once instead of counting all the way around.
    assign w_wrap = (r_cnt >= i_div);
    assign o_tick = !i_clear && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with one shared period counter.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : 1 runs the counter, 0 holds it idle (outputs low)
//   center       : 0 edge-aligned, 1 center-aligned; taken at period boundaries
//   prescale     : counter advances once every prescale+1 cycles
//   period       : requested terminal count
//   duty         : packed per-channel compare values, channel i at [i*WIDTH +: WIDTH]
//   load         : strobe capturing period/duty into the shadow registers
//   pending      : shadow holds values not yet applied
//   period_start : one-cycle pulse in the cycle after each period boundary
//   out          : registered PWM outputs
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int PRE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      center,
    input  logic [PRE_WIDTH-1:0]      prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic                      pending,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       out
);

    // Active and shadow settings
    logic [WIDTH-1:0] r_p_act;
    logic [WIDTH-1:0] r_p_sh;
    logic [WIDTH-1:0] r_d_act [CHANNELS];
    logic [WIDTH-1:0] r_d_sh  [CHANNELS];
    logic             r_pending;

    // Counter state
    logic [WIDTH-1:0] r_cnt;
    logic             r_dir_dn;   // 1 while counting down in center mode
    logic             r_mode;     // mode latched at the last boundary
    logic             r_fresh;    // no boundary seen since reset/disable

    logic                r_period_start;
    logic [CHANNELS-1:0] r_out;

    logic                    w_tick;
    logic [WIDTH-1:0]        w_p_eff;
    logic                    w_going_dn;
    logic                    w_bnd;
    logic [WIDTH-1:0]        w_cnt_nxt;
    logic                    w_dir_nxt;
    logic                    w_apply;
    logic [CHANNELS-1:0]     w_cmp;
    logic [DUTY_VEC_MAX-1:0] w_duty_ext;

    assign w_duty_ext = DUTY_VEC_MAX'(duty);

    pwm_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!enable),
        .i_div   (prescale),
        .o_tick  (w_tick)
    );

    // Next counter value and boundary detection. The first tick after
    // reset or enable is itself a boundary: it starts a period at 0.
    always_comb begin
        w_p_eff    = (r_p_act == '0) ? WIDTH'(1) : r_p_act;
        w_going_dn = 1'b0;
        w_bnd      = 1'b0;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir_dn;
        if (w_tick) begin
            if (r_fresh) begin
                w_bnd     = 1'b1;
                w_cnt_nxt = '0;
                w_dir_nxt = 1'b0;
            end else if (r_mode == MODE_EDGE) begin
                if (r_cnt >= r_p_act) begin
                    w_bnd     = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end else begin
                // Turning at the top is folded into the down step so the
                // terminal value is shown for a single tick only.
                w_going_dn = r_dir_dn || (r_cnt >= w_p_eff);
                if (w_going_dn) begin
                    if (r_cnt <= WIDTH'(1)) begin
                        w_bnd     = 1'b1;
                        w_cnt_nxt = '0;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                        w_dir_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_dir_nxt = 1'b0;
                end
            end
        end
    end

    // Shadow values reach the active set at a boundary, or at once while idle.
    assign w_apply = r_pending && (!enable || w_bnd);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
        assign w_cmp[g] = (r_cnt < r_d_act[g]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_dir_dn       <= 1'b0;
            r_mode         <= MODE_EDGE;
            r_fresh        <= 1'b1;
            r_p_act        <= '0;
            r_p_sh         <= '0;
            r_pending      <= 1'b0;
            r_period_start <= 1'b0;
            r_out          <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_d_act[i] <= '0;
                r_d_sh[i]  <= '0;
            end
        end else begin
            if (!enable) begin
                r_cnt    <= '0;
                r_dir_dn <= 1'b0;
                r_fresh  <= 1'b1;
                r_mode   <= center;
            end else begin
                r_cnt    <= w_cnt_nxt;
                r_dir_dn <= w_dir_nxt;
                if (w_bnd) begin
                    r_mode  <= center;
                    r_fresh <= 1'b0;
                end
            end

            if (w_apply) begin
                r_p_act <= r_p_sh;
                r_d_act <= r_d_sh;
            end

            // A load in the apply cycle refills the shadow and keeps pending.
            if (load) begin
                r_p_sh <= period;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_d_sh[i] <= WIDTH'(duty_slice(w_duty_ext, i, WIDTH));
                end
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end

            r_period_start <= w_bnd;
            r_out          <= enable ? w_cmp : '0;
        end
    end

    assign pending      = r_pending;
    assign period_start = r_period_start;
    assign out          = r_out;

endmodule
